dnn_accel_debug_scan_bridge: RTL and testbench
==============================================

// Module: dnn_accel_debug_scan_bridge
// PURPOSE
//  Parametrised debug scan bridge between the virtual-JTAG scan strobes and the CPU/accelerator debug logic.
//  Captures per-channel status into a DR_W shift register and shifts it out serially.
//  On update, presents the shifted word as a channel-tagged command over a valid/ready handshake.
//  Generalises the fixed 2-bit-IR / 38-bit-DR debug slave to N channels with overrun tracking.
// PARAMETERS
//  DR_W     38  data-register width (bits shifted per scan)
//  IR_W     2   instruction width; selects channel
//  NUM_CH   4   channel count, <= 2**IR_W
//  CNT_W    8   width of saturating dropped-update counter
// PORTS
//  clk           in   1              system clock; all scan strobes arrive pre-synchronised as 1-cycle enables
//  reset         in   1              asynchronous, active-high reset
//  scan_cdr      in   1              capture-DR strobe
//  scan_sdr      in   1              shift-DR strobe (one bit per cycle asserted)
//  scan_udr      in   1              update-DR strobe
//  scan_uir      in   1              update-IR strobe
//  scan_tdi      in   1              serial data in
//  ir_in         in   IR_W           instruction value, sampled on scan_uir
//  capture_data  in   NUM_CH*DR_W    per-channel capture words, channel c at [c*DR_W +: DR_W]
//  cmd_ready     in   1              consumer accepts cmd
//  scan_tdo      out  1              serial data out = sr[0]
//  ir_q          out  IR_W           latched instruction
//  cmd_valid     out  1              command pending
//  cmd_ch        out  IR_W           channel of pending command
//  cmd_data      out  DR_W           shifted word (jdo equivalent)
//  overrun       out  1              sticky: update arrived while command pending
//  drop_cnt      out  CNT_W          saturating count of dropped updates
//  parity_err    out  1              sticky parity failure (DEBUG_SCAN_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  Reset: sr, ir_q, cmd_*, overrun, drop_cnt, parity_err all 0; FSM -> IDLE; scan_tdo=0.
//  FSM states: IDLE, SHIFT, PEND. Strobe priority when simultaneous: cdr > sdr > udr; uir independent.
//  cdr (any state): sr <= capture_data[ir_q]; ir_q >= NUM_CH captures all-zero; -> SHIFT (or stays PEND).
//  sdr: sr <= {scan_tdi, sr[DR_W-1:1]}; scan_tdo reflects sr[0] the cycle after each shift.
//  uir: ir_q <= ir_in next cycle; does not alter a pending cmd_ch.
//  udr, no cmd pending: cmd_data<=sr, cmd_ch<=ir_q, cmd_valid<=1 next cycle; FSM -> PEND.
//  udr with ir_q >= NUM_CH: ignored (no cmd, no overrun).
//  PEND: cmd_valid held with stable cmd_ch/cmd_data until cmd_valid&&cmd_ready; clears next cycle -> IDLE.
//  udr while PEND and not accepted this cycle: cmd unchanged, overrun<=1, drop_cnt+1 saturating at 2**CNT_W-1.
//  udr in same cycle as acceptance: new cmd loads, cmd_valid stays 1 (back-to-back, no overrun).
//  Latency: udr -> cmd_valid 1 cycle; cdr -> first scan_tdo bit 1 cycle.
//  overrun/drop_cnt/parity_err clear only on reset.
//  Reset mid-scan: partial shift discarded, pending cmd lost, no spurious cmd after release.
// CONFIGURATION
//  DEBUG_SCAN_PARITY_EN defined: sr[DR_W-1] is even parity over sr[DR_W-2:0]; on udr
//   with mismatch no cmd issued, parity_err<=1; cmd_data[DR_W-1] forced 0 on good words.
//  Undefined: all DR_W bits are payload, parity_err tied 0, no checking logic.
// STRUCTURE
//  Package dnn_accel_debug_pkg: FSM state enum (IDLE/SHIFT/PEND), default DR_W/IR_W constants.
//  One sub-module: dnn_accel_debug_scan_shreg (capture mux + shift register + tdo).
//  Top holds FSM, IR latch, command handshake, overrun/drop counter.
// TESTING
//  uir ir_in=2; cdr with capture ch2=38'h2A_5A5A_5A5A; 38 sdr -> tdo yields LSB-first 0x2A_5A5A_5A5A.
//  Shift in 38'h15_0000_00FF, udr, cmd_ready=0 for 3 cycles -> cmd_valid held, cmd_ch=2, data stable; ready -> clears.
//  Pending cmd, udr twice without ready -> overrun=1, drop_cnt=2, cmd_data keeps first word.
//  Ready asserted same cycle as udr -> second cmd loads, cmd_valid never drops, overrun=0.
//  Force 300 drops with CNT_W=8 -> drop_cnt=255; reset asserted mid-shift -> all outputs 0, no cmd after.
//  DEBUG_SCAN_PARITY_EN: bad-parity word -> no cmd_valid, parity_err=1; good word -> cmd issued.

Source files
------------

// File: rtl/dnn_accel_debug_pkg.sv
// rtl/dnn_accel_debug_pkg.sv - shared constants and FSM state type for the debug scan bridge
package dnn_accel_debug_pkg;

    localparam int DEF_DR_W   = 38;
    localparam int DEF_IR_W   = 2;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PEND  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/dnn_accel_debug_scan_shreg.sv
// rtl/dnn_accel_debug_scan_shreg.sv - per-channel capture mux, DR shift register and serial tdo
module dnn_accel_debug_scan_shreg
    import dnn_accel_debug_pkg::*;
#(
    parameter int DR_W   = DEF_DR_W,
    parameter int IR_W   = DEF_IR_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cdr_i,
    input  logic                   sdr_i,
    input  logic                   tdi_i,
    input  logic [IR_W-1:0]        sel_i,
    input  logic [NUM_CH*DR_W-1:0] capture_data_i,
    output logic [DR_W-1:0]        sr_o,
    output logic                   tdo_o
);

    logic [DR_W-1:0] sr_q;
    logic [DR_W-1:0] cap_word;

    // Select the capture word for the latched channel; unpopulated channels read as zero
    always_comb begin
        cap_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(sel_i) == c) begin
                cap_word = capture_data_i[c*DR_W +: DR_W];
            end
        end
    end

    // Capture has priority over shift; shifting moves LSB-first toward tdo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (cdr_i) begin
            sr_q <= cap_word;
        end else if (sdr_i) begin
            sr_q <= {tdi_i, sr_q[DR_W-1:1]};
        end
    end

    assign sr_o  = sr_q;
    assign tdo_o = sr_q[0];

endmodule

// File: rtl/dnn_accel_debug_scan_bridge.sv
// rtl/dnn_accel_debug_scan_bridge.sv - scan-to-command bridge with overrun tracking; optional DEBUG_SCAN_PARITY_EN
module dnn_accel_debug_scan_bridge
    import dnn_accel_debug_pkg::*;
#(
    parameter int DR_W   = DEF_DR_W,
    parameter int IR_W   = DEF_IR_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scan_cdr,
    input  logic                   scan_sdr,
    input  logic                   scan_udr,
    input  logic                   scan_uir,
    input  logic                   scan_tdi,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [NUM_CH*DR_W-1:0] capture_data,
    input  logic                   cmd_ready,
    output logic                   scan_tdo,
    output logic [IR_W-1:0]        ir_q,
    output logic                   cmd_valid,
    output logic [IR_W-1:0]        cmd_ch,
    output logic [DR_W-1:0]        cmd_data,
    output logic                   overrun,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   parity_err
);

    scan_state_e      state_q, state_d;
    logic [IR_W-1:0]  ir_reg_q;
    logic             cmd_valid_q, cmd_valid_d;
    logic [IR_W-1:0]  cmd_ch_q;
    logic [DR_W-1:0]  cmd_data_q;
    logic             overrun_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [DR_W-1:0]  sr;
    logic [DR_W-1:0]  load_word;
    logic             word_ok;
    logic             ch_ok;
    logic             accept, udr_hit, bad_par, load_cmd, drop;

    dnn_accel_debug_scan_shreg #(
        .DR_W   (DR_W),
        .IR_W   (IR_W),
        .NUM_CH (NUM_CH)
    ) u_shreg (
        .clk            (clk),
        .reset          (reset),
        .cdr_i          (scan_cdr),
        .sdr_i          (scan_sdr),
        .tdi_i          (scan_tdi),
        .sel_i          (ir_reg_q),
        .capture_data_i (capture_data),
        .sr_o           (sr),
        .tdo_o          (scan_tdo)
    );

`ifdef DEBUG_SCAN_PARITY_EN
    // MSB carries even parity over the payload; it is stripped from issued commands
    assign word_ok   = ~(^sr);
    assign load_word = {1'b0, sr[DR_W-2:0]};
`else
    assign word_ok   = 1'b1;
    assign load_word = sr;
`endif

    assign ch_ok = (int'(ir_reg_q) < NUM_CH);

    // Decode the update strobe against the handshake; capture/shift in the same cycle mask it
    always_comb begin
        accept      = cmd_valid_q & cmd_ready;
        udr_hit     = scan_udr & ~scan_cdr & ~scan_sdr & ch_ok;
        bad_par     = udr_hit & ~word_ok;
        load_cmd    = udr_hit & word_ok & (~cmd_valid_q | accept);
        drop        = udr_hit & word_ok & cmd_valid_q & ~accept;
        cmd_valid_d = load_cmd | (cmd_valid_q & ~accept);
        state_d     = state_q;
        if (cmd_valid_d) begin
            state_d = ST_PEND;
        end else if (scan_cdr) begin
            state_d = ST_SHIFT;
        end else if (accept) begin
            state_d = ST_IDLE;
        end
    end

    // FSM and command handshake registers; command fields only change on a load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_ch_q    <= '0;
            cmd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            if (load_cmd) begin
                cmd_ch_q   <= ir_reg_q;
                cmd_data_q <= load_word;
            end
        end
    end

    // Instruction latch; independent of the DR strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_reg_q <= '0;
        end else if (scan_uir) begin
            ir_reg_q <= ir_in;
        end
    end

    // Sticky overrun flag and saturating count of updates dropped while a command waits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overrun_q <= 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef DEBUG_SCAN_PARITY_EN
    logic parity_err_q;

    // Sticky parity failure seen on an update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else if (bad_par) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`else
    logic unused_bad_par;
    assign unused_bad_par = bad_par;
    assign parity_err     = 1'b0;
`endif

    assign ir_q      = ir_reg_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_ch    = cmd_ch_q;
    assign cmd_data  = cmd_data_q;
    assign overrun   = overrun_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_dnn_accel_debug_scan_bridge.sv
// tb/tb_dnn_accel_debug_scan_bridge.sv - scoreboard bench for the debug scan bridge
module tb_dnn_accel_debug_scan_bridge;

    localparam int DR_W   = 38;
    localparam int IR_W   = 2;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   scan_cdr = 1'b0, scan_sdr = 1'b0, scan_udr = 1'b0, scan_uir = 1'b0;
    logic                   scan_tdi = 1'b0;
    logic [IR_W-1:0]        ir_in = '0;
    logic [NUM_CH*DR_W-1:0] capture_data;
    logic                   cmd_ready = 1'b0;
    logic                   scan_tdo;
    logic [IR_W-1:0]        ir_q;
    logic                   cmd_valid;
    logic [IR_W-1:0]        cmd_ch;
    logic [DR_W-1:0]        cmd_data;
    logic                   overrun;
    logic [CNT_W-1:0]       drop_cnt;
    logic                   parity_err;

    typedef struct {
        logic [IR_W-1:0] ch;
        logic [DR_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    dnn_accel_debug_scan_bridge #(
        .DR_W(DR_W), .IR_W(IR_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .scan_cdr(scan_cdr), .scan_sdr(scan_sdr), .scan_udr(scan_udr), .scan_uir(scan_uir),
        .scan_tdi(scan_tdi), .ir_in(ir_in), .capture_data(capture_data), .cmd_ready(cmd_ready),
        .scan_tdo(scan_tdo), .ir_q(ir_q), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
        .cmd_data(cmd_data), .overrun(overrun), .drop_cnt(drop_cnt), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DR_W-1:0] fix_par(input logic [DR_W-1:0] w);
        logic [DR_W-1:0] r;
        r = w;
`ifdef DEBUG_SCAN_PARITY_EN
        r[DR_W-1] = ^w[DR_W-2:0];
`endif
        return r;
    endfunction

    function automatic logic [DR_W-1:0] exp_data(input logic [DR_W-1:0] w);
        logic [DR_W-1:0] r;
        r = w;
`ifdef DEBUG_SCAN_PARITY_EN
        r[DR_W-1] = 1'b0;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_uir(input logic [IR_W-1:0] v);
        scan_uir = 1'b1; ir_in = v; tick(); scan_uir = 1'b0;
    endtask

    task automatic do_cdr();
        scan_cdr = 1'b1; tick(); scan_cdr = 1'b0;
    endtask

    task automatic do_udr();
        scan_udr = 1'b1; tick(); scan_udr = 1'b0;
    endtask

    task automatic push(input logic [IR_W-1:0] ch, input logic [DR_W-1:0] d);
        exp_t e;
        e.ch = ch; e.data = d;
        exp_q.push_back(e);
    endtask

    // Shift w in LSB-first while recording tdo ahead of each shift edge
    task automatic shift_word(input logic [DR_W-1:0] w, input int nbits, output logic [DR_W-1:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            got[i]   = scan_tdo;
            scan_sdr = 1'b1;
            scan_tdi = w[i];
            tick();
        end
        scan_sdr = 1'b0;
        scan_tdi = 1'b0;
    endtask

    task automatic accept_one();
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    endtask

    // Monitor: every accepted command must match the oldest expected one
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", {63'd0, cmd_valid}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("cmd_ch", 64'(cmd_ch), 64'(mon_e.ch));
                check("cmd_data", 64'(cmd_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        logic [DR_W-1:0] got, wa, wb, wc, wd;
        capture_data = {38'h2A_5A5A_5A5A, 38'h3F_0F0F_0F0F, 38'h00_1111_1111};
        tick(); tick();
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_misc", {overrun, drop_cnt, parity_err, ir_q, scan_tdo}, 64'd0);
        reset = 1'b0;
        tick();

        // Capture channel 2 and read it back serially
        do_uir(2'd2);
        check("ir_q", 64'(ir_q), 64'd2);
        do_cdr();
        wa = fix_par(38'h15_0000_00FF);
        shift_word(wa, DR_W, got);
        check("tdo_capture_ch2", 64'(got), 64'h2A_5A5A_5A5A);

        // Held command while the consumer stalls
        push(2'd2, exp_data(wa));
        do_udr();
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", 64'(cmd_valid), 64'd1);
            check("hold_ch", 64'(cmd_ch), 64'd2);
            check("hold_data", 64'(cmd_data), 64'(exp_data(wa)));
            tick();
        end
        accept_one();
        check("valid_clears", 64'(cmd_valid), 64'd0);

        // Unpopulated channel: captures zero and ignores update
        do_uir(2'd3);
        do_cdr();
        shift_word(38'h0A_BCDE_F012, DR_W, got);
        check("tdo_capture_ch3", 64'(got), 64'd0);
        do_udr();
        tick();
        check("ch3_no_cmd", 64'(cmd_valid), 64'd0);
        check("ch3_no_overrun", 64'(overrun), 64'd0);
        do_uir(2'd1);

        // Back-to-back: update lands in the acceptance cycle
        wc = fix_par(38'h01_2345_6789);
        wd = fix_par(38'h3E_DCBA_9876);
        shift_word(wc, DR_W, got);
        push(2'd1, exp_data(wc));
        do_udr();
        shift_word(wd, DR_W, got);
        push(2'd1, exp_data(wd));
        cmd_ready = 1'b1; scan_udr = 1'b1;
        tick();
        cmd_ready = 1'b0; scan_udr = 1'b0;
        check("b2b_valid", 64'(cmd_valid), 64'd1);
        check("b2b_data", 64'(cmd_data), 64'(exp_data(wd)));
        check("b2b_overrun", 64'(overrun), 64'd0);
        accept_one();

        // Two dropped updates while a command waits
        wa = fix_par(38'h11_2233_4455);
        wb = fix_par(38'h22_6677_8899);
        shift_word(wa, DR_W, got);
        push(2'd1, exp_data(wa));
        do_udr();
        shift_word(wb, DR_W, got);
        do_udr();
        do_udr();
        check("overrun", 64'(overrun), 64'd1);
        check("drop_cnt_2", 64'(drop_cnt), 64'd2);
        check("overrun_keeps_data", 64'(cmd_data), 64'(exp_data(wa)));
        accept_one();

`ifdef DEBUG_SCAN_PARITY_EN
        shift_word(fix_par(38'h05_0505_0505) ^ (38'd1 << (DR_W-1)), DR_W, got);
        do_udr();
        tick();
        check("par_bad_no_cmd", 64'(cmd_valid), 64'd0);
        check("parity_err", 64'(parity_err), 64'd1);
        wa = fix_par(38'h05_0505_0505);
        shift_word(wa, DR_W, got);
        push(2'd1, exp_data(wa));
        do_udr();
        check("par_good_cmd", 64'(cmd_valid), 64'd1);
        accept_one();
`else
        check("parity_err_tied", 64'(parity_err), 64'd0);
`endif

        // Saturate the drop counter: 300 more drops on top of 2
        wa = fix_par(38'h33_CCCC_3333);
        shift_word(wa, DR_W, got);
        push(2'd1, exp_data(wa));
        do_udr();
        scan_udr = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        scan_udr = 1'b0;
        check("drop_cnt_sat", 64'(drop_cnt), 64'd255);
        check("sat_keeps_data", 64'(cmd_data), 64'(exp_data(wa)));

        // Reset mid-shift with a command still pending
        do_cdr();
        shift_word(38'h3F_FFFF_FFFF, 10, got);
        reset = 1'b1;
        exp_q.delete();
        #2;
        check("midrst_valid", 64'(cmd_valid), 64'd0);
        check("midrst_data", {cmd_data, cmd_ch}, 64'd0);
        check("midrst_misc", {overrun, drop_cnt, parity_err, ir_q, scan_tdo}, 64'd0);
        tick();
        reset = 1'b0;
        cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_no_cmd", 64'(cmd_valid), 64'd0);
        end
        cmd_ready = 1'b0;
        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
